// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path types and helpers: halfword type, length constants,
// aligner occupancy states and the RVC length decode.
package rv_fetch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ILEN      = 32;
    localparam int unsigned HLEN      = 16;
    localparam int unsigned BUF_DEPTH = 3;

    typedef logic [HLEN-1:0] halfword_t;

    // Aligner buffer occupancy: number of valid halfwords held.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } occ_state_t;

    // A halfword starts a 16-bit instruction unless its low two bits are 11.
    function automatic logic is_compressed(input halfword_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: turns a stream of 32-bit memory words into a
// stream of 16/32-bit instructions, handling straddling instructions and
// halfword-aligned redirects.
module fetch_aligner
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] fetch_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [ILEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_compressed,
    output logic            inst_valid,
    input  logic            inst_ready
);

    occ_state_t      r_state;
    occ_state_t      w_state_next;
    halfword_t       r_buf [BUF_DEPTH];
    halfword_t       w_buf_next [BUF_DEPTH];
    logic            r_skip;
    logic            w_skip_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_fetch_addr;
    logic [XLEN-1:0] w_fetch_next;

    logic [1:0]      w_count;
    logic            w_hw0_comp;
    logic            w_inst_avail;
    logic            w_mem_fire;
    logic            w_inst_fire;
    logic [1:0]      w_consumed;
    logic [1:0]      w_appended;
    logic [1:0]      w_keep;
    logic [1:0]      w_count_sum;

    // Decode what the oldest buffered halfword needs and whether it is complete.
    assign w_count      = r_state;
    assign w_hw0_comp   = is_compressed(r_buf[0]);
    assign w_inst_avail = w_hw0_comp ? (w_count >= 2'd1) : (w_count >= 2'd2);

    // Instruction presentation comes from buffer state; redirect only masks valid.
    assign inst_valid      = w_inst_avail && !redirect;
    assign inst_compressed = w_inst_avail && w_hw0_comp;
    assign inst_out        = !w_inst_avail ? '0 :
                             w_hw0_comp    ? {16'h0000, r_buf[0]} :
                                             {r_buf[1], r_buf[0]};
    assign inst_pc         = r_pc;
    assign fetch_addr      = r_fetch_addr;

    // Accept a word only while at least two halfword slots are free.
    assign mem_ready   = (w_count <= 2'd1) && !redirect;
    assign w_mem_fire  = mem_valid && mem_ready;
    assign w_inst_fire = inst_valid && inst_ready;

    assign w_consumed  = !w_inst_fire ? 2'd0 : (w_hw0_comp ? 2'd1 : 2'd2);
    assign w_appended  = !w_mem_fire  ? 2'd0 : (r_skip ? 2'd1 : 2'd2);
    assign w_keep      = w_count - w_consumed;
    assign w_count_sum = w_keep + w_appended;

    // Next-state: drop consumed halfwords, append the new word, advance PCs.
    always_comb begin
        w_state_next = r_state;
        w_buf_next   = r_buf;
        w_skip_next  = r_skip;
        w_pc_next    = r_pc;
        w_fetch_next = r_fetch_addr;

        case (w_consumed)
            2'd1: begin
                w_buf_next[0] = r_buf[1];
                w_buf_next[1] = r_buf[2];
            end
            2'd2: begin
                w_buf_next[0] = r_buf[2];
            end
            default: ;
        endcase

        // w_keep is at most 1 here because mem_ready requires count <= 1.
        if (w_mem_fire) begin
            if (r_skip) begin
                case (w_keep)
                    2'd0:    w_buf_next[0] = mem_data[31:16];
                    2'd1:    w_buf_next[1] = mem_data[31:16];
                    default: ;
                endcase
            end else begin
                case (w_keep)
                    2'd0: begin
                        w_buf_next[0] = mem_data[15:0];
                        w_buf_next[1] = mem_data[31:16];
                    end
                    2'd1: begin
                        w_buf_next[1] = mem_data[15:0];
                        w_buf_next[2] = mem_data[31:16];
                    end
                    default: ;
                endcase
            end
            w_skip_next  = 1'b0;
            w_fetch_next = r_fetch_addr + 32'd4;
        end

        if (w_inst_fire) begin
            w_pc_next = r_pc + 32'({w_consumed, 1'b0});
        end

        w_state_next = occ_state_t'(w_count_sum);

        // Redirect flushes the buffer and restarts fetch at the word holding the target.
        if (redirect) begin
            w_state_next = S0;
            w_buf_next   = r_buf;
            w_skip_next  = redirect_pc[1];
            w_pc_next    = redirect_pc;
            w_fetch_next = {redirect_pc[31:2], 2'b00};
        end
    end

    // State register with synchronous reset overriding redirect and transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S0;
            r_skip       <= RESET_PC[1];
            r_pc         <= {RESET_PC[31:1], 1'b0};
            r_fetch_addr <= {RESET_PC[31:2], 2'b00};
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_skip       <= w_skip_next;
            r_pc         <= w_pc_next;
            r_fetch_addr <= w_fetch_next;
            r_buf        <= w_buf_next;
        end
    end

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, fetch PC after reset (bit 0 ignored).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fetch_addr  output  32  word-aligned address of next word requested from instruction memory.
REQ-005 mem_data  input  32  instruction word at fetch_addr, little-endian halfwords.
REQ-006 mem_valid  input  1  mem_data valid.
REQ-007 mem_ready  output  1  aligner accepts mem_data this cycle.
REQ-008 redirect  input  1  flush request (branch/jump taken).
REQ-009 redirect_pc  input  32  new PC on redirect, halfword-aligned.
REQ-010 inst_out  output  32  aligned instruction; bits 31:16 zero when compressed.
REQ-011 inst_pc  output  32  PC of inst_out.
REQ-012 inst_compressed  output  1  inst_out is 16-bit; drives decompressor activate.
REQ-013 inst_valid  output  1  inst_out/inst_pc/inst_compressed valid.
REQ-014 inst_ready  input  1  downstream consumes instruction.

Function
REQ-015 The block SHALL hold a 3-halfword buffer with occupancy count 0..3 (states S0..S3) plus a skip flag.
REQ-016 Word transfer SHALL occur when mem_valid && mem_ready; instruction transfer when inst_valid && inst_ready.
REQ-017 mem_ready SHALL be 1 iff count <= 1 and redirect == 0.
REQ-018 A transferred word SHALL append both halfwords (low first), or only the upper halfword when skip == 1, and then clear skip.
REQ-019 fetch_addr SHALL increment by 4 on each word transfer.
REQ-020 Oldest halfword [1:0] != 2'b11 SHALL present compressed: inst_valid = (count >= 1), inst_out = {16'h0, hw0}.
REQ-021 Oldest halfword [1:0] == 2'b11 SHALL present 32-bit: inst_valid = (count >= 2), inst_out = {hw1, hw0}.
REQ-022 inst_out, inst_pc, inst_compressed and inst_valid SHALL be driven combinationally from buffer state only (no input-to-output path except redirect forcing inst_valid = 0).
REQ-023 On instruction transfer, the block SHALL remove 1 or 2 halfwords and advance inst_pc by 2 or 4 (modulo 2^32).
REQ-024 Same-cycle word and instruction transfers SHALL both take effect: count_next = count - consumed + appended, never above 3.
REQ-025 Latency: a word accepted at edge N SHALL make its instruction visible in cycle N+1 when the buffer was empty.
REQ-026 A 32-bit instruction spanning two words SHALL be presented only once both halves are buffered, with inst_pc equal to the address of its low halfword.
REQ-027 redirect SHALL take priority over all transfers: inst_valid = 0 and mem_ready = 0 in that cycle.
REQ-028 redirect SHALL set next count = 0, inst_pc = redirect_pc, fetch_addr = {redirect_pc[31:2], 2'b00}, and skip = redirect_pc[1].
REQ-029 A word presented by memory in the redirect cycle SHALL be discarded.
REQ-030 Address wrap 32'hFFFF_FFFC -> 32'h0000_0000 SHALL wrap silently.

Reset
REQ-031 While reset == 1 at a clock edge, the block SHALL set count = 0, skip = RESET_PC[1], inst_pc = RESET_PC, and fetch_addr = {RESET_PC[31:2], 2'b00}.
REQ-032 During and after reset with an empty buffer, outputs SHALL be inst_valid = 0 and inst_out = 0; mem_ready SHALL be 1 from the first cycle after reset.
REQ-033 Reset SHALL override redirect and any in-flight transfer; partial spanning instructions SHALL be dropped.

Structure
REQ-034 Shared package rv_fetch_pkg SHALL hold the halfword typedef, the ILEN/XLEN constants, and the function is_compressed(halfword).
REQ-035 The decompressor SHALL import rv_fetch_pkg.
REQ-036 No sub-module is required; buffer, count and PC logic SHALL reside in fetch_aligner.

Verification
REQ-037 Reset, then words 32'h0001_4501 and 32'h0000_0001 with inst_ready = 1 -> compressed 16'h4501 @ PC 0, then 16'h0001 @ PC 2, then 16'h0001 @ PC 4, then 16'h0000 @ PC 6.
REQ-038 Words 32'h0513_0001 and 32'h0000_0000 -> compressed 16'h0001 @ PC 0, then 32-bit 32'h0000_0513 @ PC 2, presented only after the second word is accepted.
REQ-039 inst_ready = 0 with words streaming -> count reaches at most 3, mem_ready deasserts, and no halfword is lost or duplicated after inst_ready = 1.
REQ-040 Redirect to 32'h0000_0102 -> fetch_addr = 32'h0000_0100; the lower halfword of the next word is dropped; first inst_pc = 32'h0000_0102.
REQ-041 Redirect asserted with mem_valid = 1 and inst_ready = 1 -> no transfer occurs, and the buffered instruction is never presented again.
REQ-042 Reset asserted mid-span with count = 1 holding 16'hxx13 -> count = 0, inst_pc = RESET_PC, and no stale instruction appears afterwards.
